// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative RV M-extension multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  // rs1 is treated as two's complement.
  function automatic logic is_signed_op(input logic [2:0] f);
    return (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
  endfunction

  // rs2 is treated as two's complement.
  function automatic logic rs2_signed(input logic [2:0] f);
    return (f == MULH) || (f == DIV) || (f == REM);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 non-restoring divider on unsigned magnitudes, one quotient bit per cycle.
module mdu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic                   run_q, run_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [XLEN+1:0] rem_q, rem_d, rem_sh;
  logic signed [XLEN+1:0] dvs_q;
  logic [XLEN-1:0]        quo_q, quo_d;

  // Partial remainder stays within [-D, D); the shifted value needs one extra bit.
  always_comb begin
    rem_sh = {rem_q[XLEN:0], quo_q[XLEN-1]};
    rem_d  = rem_q[XLEN+1] ? rem_sh + dvs_q : rem_sh - dvs_q;
    quo_d  = {quo_q[XLEN-2:0], ~rem_d[XLEN+1]};
  end

  assign done_o = run_q && (cnt_q == CW'(XLEN - 1));
  assign quot_o = quo_q;
  assign rem_o  = rem_q[XLEN+1] ? rem_q[XLEN-1:0] + dvs_q[XLEN-1:0] : rem_q[XLEN-1:0];

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (abort_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= {2'b00, divisor_i};
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/mdu_core.sv
// Iterative RV M-extension unit: radix-4 Booth multiply, non-restoring divide,
// one-cycle fast path for divide special cases, result held until the pipeline frees up.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_in_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mdu_in_1,
  input  logic [XLEN-1:0] mdu_in_2,
  input  logic            cpu_busy,
  input  logic            mdu_flush,
  output logic [XLEN-1:0] mdu_out,
  output logic            mdu_out_valid,
  output logic            mdu_busy
);

  localparam int CW = $clog2(XLEN);
  localparam int AW = 2 * XLEN + 2;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            vld_q, vld_d;
  logic            busy_q;

  logic [1:0]             op_q;
  logic [XLEN-1:0]        rs1_q;
  logic signed [XLEN:0]   mcand_q;
  logic [AW-1:0]          acc_q, acc_n;
  logic                   corr_q, neg_q_q, neg_r_q, dbz_q, ovf_q;

  logic                   accept, sgn_in, dbz_in, ovf_in, div_start, div_done;
  logic [XLEN-1:0]        dvd_abs, dvs_abs, div_quo, div_rem;
  logic signed [XLEN:0]   mcand_in;
  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        prod_hi, mul_res, quo_s, rem_s, div_res;

  // One radix-4 Booth digit: add d*mcand to the high part, then shift the whole accumulator by 2.
  function automatic logic [AW-1:0] booth_step(input logic [AW-1:0] acc,
                                               input logic signed [XLEN:0] mc);
    logic signed [XLEN+2:0] p, m1, sum;
    p  = {{2{acc[AW-1]}}, acc[AW-1:XLEN+1]};
    m1 = {{2{mc[XLEN]}}, mc};
    case (acc[2:0])
      3'b001, 3'b010: sum = p + m1;
      3'b011:         sum = p + (m1 <<< 1);
      3'b100:         sum = p - (m1 <<< 1);
      3'b101, 3'b110: sum = p - m1;
      default:        sum = p;
    endcase
    return {sum, acc[XLEN:2]};
  endfunction

  function automatic logic [XLEN-1:0] special_res(input logic is_rem,
                                                  input logic [XLEN-1:0] dvd,
                                                  input logic dbz);
    if (dbz) return is_rem ? dvd : '1;
    return is_rem ? '0 : MIN_VAL;
  endfunction

  assign accept   = (state_q == ST_IDLE) && mdu_in_valid && !mdu_flush;
  assign sgn_in   = is_signed_op(funct3);
  assign dbz_in   = (mdu_in_2 == '0);
  assign ovf_in   = funct3[2] && !funct3[0] && (mdu_in_1 == MIN_VAL) && (&mdu_in_2);
  assign dvd_abs  = (sgn_in && mdu_in_1[XLEN-1]) ? -mdu_in_1 : mdu_in_1;
  assign dvs_abs  = (sgn_in && mdu_in_2[XLEN-1]) ? -mdu_in_2 : mdu_in_2;
  assign mcand_in = {sgn_in & mdu_in_1[XLEN-1], mdu_in_1};

  // Booth treats rs2 as signed; an unsigned rs2 with its MSB set owes rs1 << XLEN.
  always_comb begin
    acc_n   = booth_step(acc_q, mcand_q);
    prod    = acc_n[2*XLEN:1];
    prod_hi = prod[2*XLEN-1:XLEN] + (corr_q ? rs1_q : '0);
    mul_res = (op_q == 2'd0) ? prod[XLEN-1:0] : prod_hi;
  end

  always_comb begin
    quo_s   = neg_q_q ? -div_quo : div_quo;
    rem_s   = neg_r_q ? -div_rem : div_rem;
    div_res = op_q[1] ? rem_s : quo_s;
    if (dbz_q || ovf_q) div_res = special_res(op_q[1], rs1_q, dbz_q);
  end

  mdu_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk_i      (clk),
    .rst_ni     (rst),
    .start_i    (div_start),
    .abort_i    (mdu_flush),
    .dividend_i (dvd_abs),
    .divisor_i  (dvs_abs),
    .done_o     (div_done),
    .quot_o     (div_quo),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    vld_d     = vld_q;
    div_start = 1'b0;
    if (mdu_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mdu_in_valid) begin
            if (!funct3[2]) begin
              state_d = ST_MUL;
              cnt_d   = '0;
            end else if (EARLY_OUT && (dbz_in || ovf_in)) begin
              state_d = ST_DONE;
              out_d   = special_res(funct3[1], mdu_in_1, dbz_in);
              vld_d   = 1'b1;
            end else begin
              state_d   = ST_DIV;
              div_start = 1'b1;
            end
          end
        end
        ST_MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN / 2 - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            out_d   = mul_res;
            vld_d   = 1'b1;
          end
        end
        ST_DIV: if (div_done) state_d = ST_FIX;
        ST_FIX: begin
          state_d = ST_DONE;
          out_d   = div_res;
          vld_d   = 1'b1;
        end
        ST_DONE: begin
          if (!cpu_busy) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= funct3[1:0];
      rs1_q   <= mdu_in_1;
      mcand_q <= mcand_in;
      acc_q   <= {{(XLEN+1){1'b0}}, mdu_in_2, 1'b0};
      corr_q  <= !rs2_signed(funct3) && mdu_in_2[XLEN-1];
      neg_q_q <= sgn_in && (mdu_in_1[XLEN-1] ^ mdu_in_2[XLEN-1]);
      neg_r_q <= sgn_in && mdu_in_1[XLEN-1];
      dbz_q   <= dbz_in;
      ovf_q   <= ovf_in;
    end else if (state_q == ST_MUL) begin
      acc_q <= acc_n;
    end
  end

  assign mdu_out       = out_q;
  assign mdu_out_valid = vld_q;
  assign mdu_busy      = busy_q;

endmodule

// File: doc/mdu_core.md
# mdu_core

Parametrised iterative multiply/divide unit executing all eight RV M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-bit datapath. Sits beside the integer ALU in the execute stage and takes operands and funct3 from the issue logic. Holds its result until the CPU pipeline is free. Multiplication uses radix-4 Booth iteration; division uses radix-2 non-restoring iteration. Architectural special cases (divide-by-zero, signed overflow) complete on a one-cycle fast path.

## Interface
Parameters:
- XLEN, 32: operand/result width; must be even and ≥ 8.
- EARLY_OUT, 1: 1 enables the one-cycle fast path for divide special cases; 0 routes them through the full iteration, with identical results.

Ports (clock is `clk`; reset is `rst`, asynchronous, active-low):
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- mdu_in_valid  input  1  operation request.
- funct3  input  3  M-extension op select (0 MUL … 7 REMU).
- mdu_in_1  input  XLEN  rs1: multiplicand or dividend.
- mdu_in_2  input  XLEN  rs2: multiplier or divisor.
- cpu_busy  input  1  pipeline stalled; result must be held.
- mdu_flush  input  1  abort the in-flight operation (branch or exception).
- mdu_out  output  XLEN  result.
- mdu_out_valid  output  1  mdu_out valid.
- mdu_busy  output  1  unit cannot accept an operation.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. mdu_busy = (state != IDLE).
- Accept: rising edge with mdu_in_valid=1 in IDLE. Operands and funct3 are latched on that edge. Inputs are ignored outside IDLE.
- IDLE → MUL when funct3[2]=0. IDLE → DIV when funct3[2]=1.
- IDLE → DONE directly when funct3[2]=1 and EARLY_OUT=1 and either divisor=0 or (signed op and dividend=MIN and divisor=−1).
- MUL: performs XLEN/2 Booth iterations on a 2·XLEN+2-bit accumulator.
  - Operands are sign- or zero-extended per op: MULH signed×signed; MULHSU signed rs1×unsigned rs2; MULHU and MUL unsigned.
  - After the last iteration: MUL → DONE.
  - MUL selects product[XLEN-1:0]; MULH, MULHSU and MULHU select product[2·XLEN-1:XLEN].
- DIV: operates on absolute values for signed ops and performs XLEN iterations, then → FIX.
- FIX: performs the remainder restore step.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - FIX → DONE.
- Special-case results:
  - Divide-by-zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow: DIV = MIN; REM = 0.
- DONE: mdu_out_valid=1, and mdu_out is stable. DONE → IDLE on the first edge with cpu_busy=0.
- Flush: an edge with mdu_flush=1 forces IDLE from any state.
  - Clears mdu_out_valid.
  - Takes priority over acceptance and over cpu_busy.
  - No result is ever produced for a flushed operation.
- Reset mid-operation: the operation is abandoned and no result is produced.

## Timing
- Reset values: mdu_out=0, mdu_out_valid=0, mdu_busy=0, state=IDLE, iteration counter=0.
- Latency is counted from the acceptance edge to the first cycle with mdu_out_valid=1:
  - multiply: XLEN/2+1 cycles (17 at XLEN=32);
  - divide: XLEN+2 cycles (34 at XLEN=32);
  - fast path: 1 cycle.
- mdu_busy stays high through DONE. The next operation can be accepted no earlier than the cycle after DONE exits, so back-to-back issue costs one bubble.
- When cpu_busy=0 in the first DONE cycle, mdu_out_valid is high for exactly one cycle.
- mdu_flush and cpu_busy both high in DONE: flush wins; the unit goes to IDLE.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package mdu_pkg:
  - enum mdu_op_e: MUL=0 … REMU=7;
  - enum mdu_state_e;
  - function is_signed_op(funct3).
- Sub-module mdu_div_iter (XLEN param): non-restoring divide datapath and iteration counter, with start/done handshake.
- Booth multiplier, sign handling, special-case detection and the FSM live in mdu_core.

## Test plan
- MUL 7×0xFFFFFFFD (−3) → 0xFFFFFFEB, valid 17 cycles after accept. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each valid 34 cycles after accept.
- Special cases with EARLY_OUT=1:
  - DIVU 100/0 → 0xFFFFFFFF at latency 1;
  - REM 0x80000000/0xFFFFFFFF → 0 at latency 1;
  - same cases with EARLY_OUT=0 → same values at latency 34.
- cpu_busy held high for 5 cycles in DONE → mdu_out_valid and mdu_out stable for those 5 cycles, then valid for one more cycle, then IDLE with mdu_busy=0.
- mdu_flush asserted at iteration 10 of a DIV, with a new MUL request in the same cycle → IDLE, no valid pulse, MUL not accepted; a MUL accepted on the next cycle completes normally.
- rst low mid-MUL → all outputs 0 immediately (asynchronous); after release, an accept works normally.
